// File: rtl/bank_ram_phy_if.sv
// bank_ram_bus: command/write/read channel bundle for bank_ram_phy.
// Parity sideband (parity_inj/parity_err) exists only when BANK_RAM_PARITY_EN is defined.
interface bank_ram_phy_if #(
    parameter int unsigned NUM_BANKS  = 5,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 9
);
    logic                            cmd_valid;
    logic                            cmd_ready;
    logic                            cmd_rw;
    logic [NUM_BANKS-1:0]            cmd_mask;
    logic [ADDR_WIDTH-1:0]           cmd_addr;
    logic                            wvalid;
    logic                            wready;
    logic [NUM_BANKS*DATA_WIDTH-1:0] wdata;
    logic                            rvalid;
    logic [NUM_BANKS*DATA_WIDTH-1:0] rdata;
`ifdef BANK_RAM_PARITY_EN
    logic                            parity_inj;
    logic [NUM_BANKS-1:0]            parity_err;

    modport master (
        output cmd_valid, cmd_rw, cmd_mask, cmd_addr, wvalid, wdata, parity_inj,
        input  cmd_ready, wready, rvalid, rdata, parity_err
    );
    modport slave (
        input  cmd_valid, cmd_rw, cmd_mask, cmd_addr, wvalid, wdata, parity_inj,
        output cmd_ready, wready, rvalid, rdata, parity_err
    );
`else
    modport master (
        output cmd_valid, cmd_rw, cmd_mask, cmd_addr, wvalid, wdata,
        input  cmd_ready, wready, rvalid, rdata
    );
    modport slave (
        input  cmd_valid, cmd_rw, cmd_mask, cmd_addr, wvalid, wdata,
        output cmd_ready, wready, rvalid, rdata
    );
`endif
endinterface

// File: rtl/bank_ram_phy.sv
// bank_ram_phy: SIMD bank RAM with zero-fill init/clear and a fixed-latency read pipeline.
// Define BANK_RAM_PARITY_EN for per-lane even-parity storage and checking.
module bank_ram_phy #(
    parameter int unsigned NUM_BANKS  = 5,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned RD_LATENCY = 2
) (
    input  logic          clk,
    input  logic          rstn,
    bank_ram_phy_if.slave bus,
    input  logic          clear_req,
    output logic          init_done
);
    localparam int unsigned NUM_WORDS = 2 ** ADDR_WIDTH;
    localparam int unsigned WORD_W    = NUM_BANKS * DATA_WIDTH;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    generate
        if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_latency
            $error("bank_ram_phy: RD_LATENCY must be in 1..4");
        end
    endgenerate

    logic [0:0]            state;
    logic [ADDR_WIDTH-1:0] init_cnt;
    logic                  accept;
    logic                  rd_accept;
    logic                  wr_exec;

    logic [WORD_W-1:0]     mem [NUM_WORDS];
    logic [WORD_W-1:0]     rd_word;
    logic [WORD_W-1:0]     rd_lanes;

    logic [RD_LATENCY-1:0] pv;
    logic [WORD_W-1:0]     pd [RD_LATENCY];

    assign bus.cmd_ready = (state == ST_RUN);
    assign bus.wready    = (state == ST_RUN);
    assign init_done     = (state == ST_RUN);

    assign accept    = bus.cmd_valid && (state == ST_RUN);
    assign rd_accept = accept && !bus.cmd_rw;
    assign wr_exec   = accept && bus.cmd_rw && bus.wvalid;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= ST_INIT;
            init_cnt <= '0;
        end else begin
            case (state)
                ST_INIT: begin
                    // init_cnt parks on the last word; it is re-zeroed on the next clear
                    if (init_cnt == '1) begin
                        state <= ST_RUN;
                    end else begin
                        init_cnt <= init_cnt + ADDR_WIDTH'(1);
                    end
                end
                default: begin
                    if (clear_req) begin
                        state    <= ST_INIT;
                        init_cnt <= '0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == ST_INIT) begin
            mem[init_cnt] <= '0;
        end else if (wr_exec) begin
            for (int unsigned i = 0; i < NUM_BANKS; i++) begin
                if (bus.cmd_mask[i]) begin
                    mem[bus.cmd_addr][i*DATA_WIDTH +: DATA_WIDTH] <= bus.wdata[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    always_comb begin
        rd_word  = mem[bus.cmd_addr];
        rd_lanes = '0;
        for (int unsigned i = 0; i < NUM_BANKS; i++) begin
            if (bus.cmd_mask[i]) begin
                rd_lanes[i*DATA_WIDTH +: DATA_WIDTH] = rd_word[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Data stages only load behind a valid, so the last stage holds rdata between reads
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pv <= '0;
            for (int unsigned k = 0; k < RD_LATENCY; k++) begin
                pd[k] <= '0;
            end
        end else begin
            pv[0] <= rd_accept;
            if (rd_accept) begin
                pd[0] <= rd_lanes;
            end
            for (int unsigned k = 1; k < RD_LATENCY; k++) begin
                pv[k] <= pv[k-1];
                if (pv[k-1]) begin
                    pd[k] <= pd[k-1];
                end
            end
        end
    end

    assign bus.rvalid = pv[RD_LATENCY-1];
    assign bus.rdata  = pd[RD_LATENCY-1];

`ifdef BANK_RAM_PARITY_EN
    logic [NUM_BANKS-1:0] par_mem [NUM_WORDS];
    logic [NUM_BANKS-1:0] rd_perr;
    logic [NUM_BANKS-1:0] pp [RD_LATENCY];

    always_ff @(posedge clk) begin
        if (state == ST_INIT) begin
            par_mem[init_cnt] <= '0;
        end else if (wr_exec) begin
            for (int unsigned i = 0; i < NUM_BANKS; i++) begin
                if (bus.cmd_mask[i]) begin
                    par_mem[bus.cmd_addr][i] <= (^bus.wdata[i*DATA_WIDTH +: DATA_WIDTH]) ^ bus.parity_inj;
                end
            end
        end
    end

    always_comb begin
        rd_perr = '0;
        for (int unsigned i = 0; i < NUM_BANKS; i++) begin
            rd_perr[i] = bus.cmd_mask[i]
                       & (par_mem[bus.cmd_addr][i] ^ (^rd_word[i*DATA_WIDTH +: DATA_WIDTH]));
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned k = 0; k < RD_LATENCY; k++) begin
                pp[k] <= '0;
            end
        end else begin
            if (rd_accept) begin
                pp[0] <= rd_perr;
            end
            for (int unsigned k = 1; k < RD_LATENCY; k++) begin
                if (pv[k-1]) begin
                    pp[k] <= pp[k-1];
                end
            end
        end
    end

    assign bus.parity_err = pv[RD_LATENCY-1] ? pp[RD_LATENCY-1] : '0;
`endif
endmodule
